// File: rtl/uartrx.sv
// 8N1 UART receiver on the negative edge of the slow UART clock: 2-flop input
// synchroniser, mid-bit sampling, byte hand-off with ready/framing/overrun flags.
module uartrx #(
    parameter int unsigned TICKSPERBIT = 16,
    parameter int unsigned WORDSZ      = 8
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              serin,
    input  logic              host_rd,
    output logic [WORDSZ-1:0] dout,
    output logic              rx_ready,
    output logic              frame_err,
    output logic              overrun
);

    localparam int unsigned CTR_W = $clog2(TICKSPERBIT);
    localparam int unsigned BIT_W = $clog2(WORDSZ + 1);
    localparam logic [CTR_W-1:0] CTR_MID  = CTR_W'(TICKSPERBIT / 2 - 1);
    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(TICKSPERBIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORDSZ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CTR_W-1:0]   ctr_q, ctr_d;
    logic [BIT_W-1:0]   bitctr_q, bitctr_d;
    logic [WORDSZ-1:0]  shift_q, shift_d;
    logic [WORDSZ-1:0]  dout_q, dout_d;
    logic               rx_ready_q, rx_ready_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;
    logic               sync1_q, sync2_q;
    logic               serin_s;

    assign serin_s   = sync2_q;
    assign dout      = dout_q;
    assign rx_ready  = rx_ready_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    // State and datapath registers; a reset mid-frame discards the partial byte.
    always_ff @(negedge clk or negedge reset_b) begin
        if (!reset_b) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= S_IDLE;
            ctr_q       <= '0;
            bitctr_q    <= '0;
            shift_q     <= '1;
            dout_q      <= '0;
            rx_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= serin;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            bitctr_q    <= bitctr_d;
            shift_q     <= shift_d;
            dout_q      <= dout_d;
            rx_ready_q  <= rx_ready_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state logic; a completing byte overrides a simultaneous host read.
    always_comb begin
        state_d     = state_q;
        ctr_d       = (ctr_q == CTR_LAST) ? '0 : ctr_q + CTR_W'(1);
        bitctr_d    = bitctr_q;
        shift_d     = shift_q;
        dout_d      = dout_q;
        rx_ready_d  = rx_ready_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;

        if (host_rd) begin
            rx_ready_d  = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!serin_s) begin
                    state_d = S_START;
                    ctr_d   = '0;
                end
            end
            S_START: begin
                if (ctr_q == CTR_MID) begin
                    ctr_d = '0;
                    if (!serin_s) begin
                        state_d  = S_BIT;
                        bitctr_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_BIT: begin
                if (ctr_q == CTR_LAST) begin
                    shift_d  = {serin_s, shift_q[WORDSZ-1:1]};
                    bitctr_d = bitctr_q + BIT_W'(1);
                    if (bitctr_q == BIT_LAST) begin
                        state_d = S_STOP;
                        ctr_d   = '0;
                    end
                end
            end
            S_STOP: begin
                if (ctr_q == CTR_LAST) begin
                    state_d = S_IDLE;
                    ctr_d   = '0;
                    if (serin_s) begin
                        dout_d     = shift_q;
                        rx_ready_d = 1'b1;
                        if (rx_ready_q && !host_rd) begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                ctr_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uartrx.sv
// Scoreboard bench for uartrx: stimulus predicts every change of the host-visible
// outputs (value and edge number); a monitor checks each change as it appears.
module tb_uartrx;

    logic       clk;
    logic       reset_b;
    logic       serin;
    logic       host_rd;
    logic [7:0] dout;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    uartrx #(.TICKSPERBIT(16), .WORDSZ(8)) dut (
        .clk      (clk),
        .reset_b  (reset_b),
        .serin    (serin),
        .host_rd  (host_rd),
        .dout     (dout),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    typedef struct {
        logic [10:0] val;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [7:0]  m_dout;
    logic        m_rdy, m_fe, m_ov;
    logic [10:0] mon_last;
    logic [10:0] mon_cur;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) cyc <= cyc + 1;

    function automatic logic [10:0] model_pack();
        return {m_dout, m_rdy, m_fe, m_ov};
    endfunction

    task automatic push_if_changed(input logic [10:0] old, input int due);
        exp_t e;
        if (model_pack() != old) begin
            e.val = model_pack();
            e.due = due;
            exp_q.push_back(e);
        end
    endtask

    // Frame completion from the receiver's host-visible rules.
    task automatic model_complete(input logic [7:0] data, input bit stop_ok, input bit rd, input int due);
        logic [10:0] old;
        old = model_pack();
        if (stop_ok) begin
            m_ov   = (m_rdy && !rd) ? 1'b1 : (rd ? 1'b0 : m_ov);
            m_fe   = rd ? 1'b0 : m_fe;
            m_dout = data;
            m_rdy  = 1'b1;
        end else begin
            m_fe  = 1'b1;
            m_rdy = rd ? 1'b0 : m_rdy;
            m_ov  = rd ? 1'b0 : m_ov;
        end
        push_if_changed(old, due);
    endtask

    task automatic model_reset();
        m_dout = 8'h00;
        m_rdy  = 1'b0;
        m_fe   = 1'b0;
        m_ov   = 1'b0;
    endtask

    task automatic check_reset(input string name);
        vectors++;
        if ({dout, rx_ready, frame_err, overrun} != model_pack()) begin
            miscompares++;
            $display("FAIL %s: got dout=%h rdy=%b fe=%b ov=%b, want dout=%h rdy=%b fe=%b ov=%b",
                     name, dout, rx_ready, frame_err, overrun, m_dout, m_rdy, m_fe, m_ov);
        end
    endtask

    // Monitor: every change of the output tuple must match the next expectation.
    always @(posedge clk) begin
        mon_cur = {dout, rx_ready, frame_err, overrun};
        if (!reset_b) begin
            mon_last = mon_cur;
        end else if (mon_cur != mon_last) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_change: got %h at edge %0d, want no change", mon_cur, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (mon_cur != e.val || cyc != e.due) begin
                    miscompares++;
                    $display("FAIL output_change: got dout=%h rdy/fe/ov=%b at edge %0d, want dout=%h rdy/fe/ov=%b at edge %0d",
                             mon_cur[10:3], mon_cur[2:0], cyc, e.val[10:3], e.val[2:0], e.due);
                end
            end
            mon_last = mon_cur;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            serin   = 1'b1;
            host_rd = 1'b0;
        end
    endtask

    task automatic pulse_rd();
        logic [10:0] old;
        @(posedge clk);
        serin   = 1'b1;
        host_rd = 1'b1;
        old = model_pack();
        m_rdy = 1'b0;
        m_fe  = 1'b0;
        m_ov  = 1'b0;
        push_if_changed(old, cyc + 1);
        @(posedge clk);
        host_rd = 1'b0;
    endtask

    // One 160-tick frame; the low stop bit is released early so it cannot re-trigger.
    task automatic send_frame(input logic [7:0] data, input bit stop_ok, input bit rd_at_stop, input int abort_at);
        logic [9:0] bits;
        int         n;
        bits = {stop_ok, data, 1'b0};
        for (int k = 0; k < 160; k++) begin
            @(posedge clk);
            if (k == 0) begin
                n = cyc + 1;
                if (abort_at < 0) model_complete(data, stop_ok, rd_at_stop, n + 154);
            end
            if (k == abort_at) begin
                #1 reset_b = 1'b0;
                serin   = 1'b1;
                host_rd = 1'b0;
                model_reset();
                repeat (3) @(posedge clk);
                check_reset("reset_midframe");
                #1 reset_b = 1'b1;
                return;
            end
            serin   = (k >= 153 && k < 160) ? 1'b1 : bits[k / 16];
            host_rd = rd_at_stop && (k == 154);
        end
    endtask

    initial begin
        int budget;
        reset_b = 1'b0;
        serin   = 1'b1;
        host_rd = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        check_reset("reset_values");
        #1 reset_b = 1'b1;
        idle(5);

        // 1: single byte, then read
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        idle(10);
        pulse_rd();
        idle(10);
        // 2: short glitch on the line
        repeat (4) begin @(posedge clk); serin = 1'b0; end
        idle(40);
        // 3: framing error, then a good byte, then read
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        idle(8);
        send_frame(8'h5A, 1'b1, 1'b0, -1);
        idle(8);
        pulse_rd();
        idle(8);
        // 4: overrun back-to-back
        send_frame(8'h11, 1'b1, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b0, -1);
        idle(8);
        pulse_rd();
        idle(8);
        // 5: read coincident with completion
        send_frame(8'h11, 1'b1, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b1, -1);
        idle(8);
        // 6: reset mid data bit 3, then a clean byte
        send_frame(8'hFF, 1'b1, 1'b0, 72);
        idle(10);
        send_frame(8'h81, 1'b1, 1'b0, -1);
        idle(8);
        pulse_rd();
        idle(8);

        // Randomised frames, gaps, reads and framing errors
        for (int i = 0; i < 40; i++) begin
            send_frame(8'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0, -1);
            if ($urandom_range(0, 2) != 0) begin
                idle($urandom_range(1, 20));
                if ($urandom_range(0, 1) == 1) pulse_rd();
                idle($urandom_range(0, 5));
            end
        end

        budget = 0;
        while (exp_q.size() != 0 && budget < 400) begin
            @(posedge clk);
            budget++;
        end
        @(posedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no completion by time %0t, want completion", $time);
        $fatal(1);
    end

endmodule
